// File: rtl/top_level.sv
// Decryption engine: recovers LFSR taps/seed from a space preamble in DM1[64..127]
// and writes the decrypted 64-byte message to DM1[0..63].

module data_mem (
  input  logic       Clk,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] raddr_i,
  output logic [7:0] rdata_o
);
  logic [7:0] Core [0:255];

  always_ff @(posedge Clk) begin
    if (we_i) Core[waddr_i] <= wdata_i;
  end

  assign rdata_o = Core[raddr_i];
endmodule

module top_level #(
  parameter int PREAMBLE_CHECK = 9,
  parameter int MSG_LEN        = 64,
  parameter int SRC_BASE       = 64
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);
  typedef enum logic [2:0] {S_IDLE, S_SEED, S_SEARCH, S_DECRYPT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [6:0]  seed_q, seed_d, lfsr_q, lfsr_d, taps_q, taps_d;
  logic [3:0]  p_q, p_d;
  logic [5:0]  i_q, i_d;
  logic        we;
  logic [7:0]  raddr, waddr, wdata, rdata;
  logic [6:0]  c_plain, step_cand, step_sel;
  logic        c_parity_unused;

  function automatic logic [6:0] tap_of(input logic [3:0] idx);
    case (idx)
      4'd0:    return 7'h60;
      4'd1:    return 7'h48;
      4'd2:    return 7'h78;
      4'd3:    return 7'h72;
      4'd4:    return 7'h6A;
      4'd5:    return 7'h69;
      4'd6:    return 7'h5C;
      4'd7:    return 7'h7E;
      default: return 7'h7B;
    endcase
  endfunction

  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  data_mem DM1 (
    .Clk     (Clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // ciphertext byte with the known space removed: equals the keystream in the preamble
  assign c_plain         = rdata[6:0] ^ 7'h20;
  assign c_parity_unused = rdata[7];
  assign step_cand       = lfsr_step(lfsr_q, tap_of(p_q));
  assign step_sel        = lfsr_step(lfsr_q, taps_q);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      seed_q  <= '0;
      lfsr_q  <= '0;
      taps_q  <= '0;
      p_q     <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      lfsr_q  <= lfsr_d;
      taps_q  <= taps_d;
      p_q     <= p_d;
      i_q     <= i_d;
    end
  end

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    lfsr_d  = lfsr_q;
    taps_d  = taps_q;
    p_d     = p_q;
    i_d     = i_q;
    case (state_q)
      S_IDLE: begin
        i_d = '0;
        p_d = '0;
        if (!Start) state_d = S_SEED;
      end
      S_SEED: begin
        seed_d  = c_plain;
        lfsr_d  = c_plain;
        p_d     = '0;
        i_d     = 6'd1;
        state_d = S_SEARCH;
      end
      S_SEARCH: begin
        if (step_cand != c_plain) begin
          lfsr_d = seed_q;
          if (p_q == 4'd8) begin
            // no candidate fits: decrypt with pattern 0 so the run still completes
            taps_d  = tap_of(4'd0);
            i_d     = '0;
            state_d = S_DECRYPT;
          end else begin
            p_d = p_q + 4'd1;
            i_d = 6'd1;
          end
        end else if (i_q == 6'(PREAMBLE_CHECK)) begin
          taps_d  = tap_of(p_q);
          lfsr_d  = seed_q;
          i_d     = '0;
          state_d = S_DECRYPT;
        end else begin
          lfsr_d = step_cand;
          i_d    = i_q + 6'd1;
        end
      end
      S_DECRYPT: begin
        lfsr_d = step_sel;
        i_d    = i_q + 6'd1;
        if (i_q == 6'(MSG_LEN - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (Start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Ack   = (state_q == S_DONE);
    we    = (state_q == S_DECRYPT);
    raddr = 8'(SRC_BASE) + {2'b00, i_q};
    waddr = {2'b00, i_q};
    wdata = {1'b0, rdata[6:0] ^ lfsr_q};
  end
endmodule

// File: tb/tb_top_level.sv
// Randomized self-checking bench for top_level: encrypts plaintexts, runs the engine,
// and compares DM1.Core against a preamble-search reference model.

module tb_top_level;
  logic Clk = 1'b0;
  logic Reset, Start, Ack;

  top_level dut (.Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack));

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [6:0] TAPS [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                      7'h69, 7'h5C, 7'h7E, 7'h7B};

  logic [7:0] pt     [64];
  logic [7:0] ct     [64];
  logic [7:0] exp_pt [64];
  logic [7:0] snap   [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] lfsr_next(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  task automatic make_pt(input int pre);
    for (int i = 0; i < 64; i++)
      pt[i] = (i < pre) ? 8'h20 : {1'b0, 7'($urandom_range(32, 126))};
  endtask

  task automatic encrypt_load(input logic [6:0] taps, input logic [6:0] seed);
    logic [6:0] l, c7;
    l = seed;
    for (int i = 0; i < 64; i++) begin
      c7 = pt[i][6:0] ^ l;
      ct[i] = {^c7, c7};
      dut.DM1.Core[64 + i] = ct[i];
      dut.DM1.Core[i] = 8'hFF;
      l = lfsr_next(l, taps);
    end
  endtask

  // Reference: first candidate whose 9 keystream states reproduce the space preamble
  task automatic build_expected();
    logic [6:0] seed, l, sel;
    bit found, ok;
    seed  = ct[0][6:0] ^ 7'h20;
    sel   = TAPS[0];
    found = 0;
    for (int p = 0; p < 9; p++) begin
      if (!found) begin
        l = seed;
        ok = 1;
        for (int k = 1; k <= 9; k++) begin
          l = lfsr_next(l, TAPS[p]);
          if (l != (ct[k][6:0] ^ 7'h20)) ok = 0;
        end
        if (ok) begin
          sel = TAPS[p];
          found = 1;
        end
      end
    end
    l = seed;
    for (int i = 0; i < 64; i++) begin
      exp_pt[i] = {1'b0, ct[i][6:0] ^ l};
      l = lfsr_next(l, sel);
    end
  endtask

  task automatic check_result(input string tag);
    int score, src_diff;
    score = 0;
    src_diff = 0;
    for (int i = 0; i < 64; i++) begin
      if (dut.DM1.Core[i] === exp_pt[i]) score++;
      if (dut.DM1.Core[64 + i] !== ct[i]) src_diff++;
    end
    chk({tag, "_score"}, score, 64);
    chk({tag, "_src_kept"}, src_diff, 0);
  endtask

  task automatic run_engine(input string tag);
    int cnt;
    Start = 1'b1;
    @(negedge Clk);
    chk({tag, "_ack_idle"}, Ack, 1'b0);
    Start = 1'b0;
    cnt = 0;
    while (!Ack && cnt < 200) begin
      @(negedge Clk);
      cnt++;
    end
    chk({tag, "_ack_in_time"}, (Ack === 1'b1 && cnt <= 160), 1);
    check_result(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string msg;
    int cnt, changed;
    logic [6:0] sd;

    Reset = 1'b1;
    Start = 1'b1;
    repeat (2) @(negedge Clk);
    chk("reset_ack", Ack, 1'b0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("hold_idle_ack", Ack, 1'b0);

    // Known message, taps 0x7E, seed 0x2A, 10-byte preamble
    msg = "Wads has worked once again";
    for (int i = 0; i < 64; i++) pt[i] = 8'h20;
    for (int k = 0; k < msg.len(); k++) pt[10 + k] = msg[k];
    encrypt_load(7'h7E, 7'h2A);
    build_expected();
    run_engine("wads");
    chk("wads_first_char", dut.DM1.Core[10], 8'h57);

    // Every tap pattern with extreme seeds and a 15-byte preamble
    for (int p = 0; p < 9; p++) begin
      for (int s = 0; s < 2; s++) begin
        make_pt(15);
        encrypt_load(TAPS[p], (s == 0) ? 7'h01 : 7'h7F);
        build_expected();
        run_engine($sformatf("tap%0d_s%0d", p, s));
      end
    end

    // All spaces with taps 0x60: pattern 0 matches first, so output is pure spaces
    for (int i = 0; i < 64; i++) pt[i] = 8'h20;
    encrypt_load(7'h60, 7'($urandom_range(1, 127)));
    build_expected();
    run_engine("spaces");
    cnt = 0;
    for (int i = 0; i < 64; i++) if (dut.DM1.Core[i] === 8'h20) cnt++;
    chk("spaces_all_0x20", cnt, 64);

    // 0x7E and '.' at the tail exercise the 64th keystream state
    make_pt(10);
    pt[62] = 8'h7E;
    pt[63] = 8'h2E;
    sd = 7'($urandom_range(1, 127));
    encrypt_load(TAPS[$urandom_range(0, 8)], sd);
    build_expected();
    run_engine("tail");
    chk("tail_byte63", dut.DM1.Core[63], exp_pt[63]);

    // Random seeds and taps
    for (int r = 0; r < 4; r++) begin
      make_pt(10);
      encrypt_load(TAPS[$urandom_range(0, 8)], 7'($urandom_range(1, 127)));
      build_expected();
      run_engine($sformatf("rnd%0d", r));
    end

    // Garbage block with no valid preamble: still completes using pattern 0
    for (int i = 0; i < 64; i++) begin
      ct[i] = 8'($urandom);
      dut.DM1.Core[64 + i] = ct[i];
      dut.DM1.Core[i] = 8'hFF;
    end
    build_expected();
    run_engine("garbage");

    // Reset during DECRYPT aborts writes; a fresh start finishes correctly
    make_pt(10);
    encrypt_load(TAPS[$urandom_range(0, 8)], 7'($urandom_range(1, 127)));
    build_expected();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    cnt = 0;
    while (dut.DM1.Core[0] === 8'hFF && cnt < 200) begin
      @(negedge Clk);
      cnt++;
    end
    chk("abort_decrypt_seen", (cnt < 200), 1);
    repeat (10) @(negedge Clk);
    Reset = 1'b1;
    Start = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort_ack", Ack, 1'b0);
    for (int i = 0; i < 64; i++) snap[i] = dut.DM1.Core[i];
    repeat (20) @(negedge Clk);
    changed = 0;
    for (int i = 0; i < 64; i++) if (dut.DM1.Core[i] !== snap[i]) changed++;
    chk("abort_no_writes", changed, 0);
    chk("abort_partial", (snap[63] === 8'hFF), 1);
    chk("abort_ack_hold", Ack, 1'b0);
    run_engine("after_abort");

    // From DONE, load a new block and restart
    chk("done_ack_high", Ack, 1'b1);
    make_pt(12);
    encrypt_load(TAPS[$urandom_range(0, 8)], 7'($urandom_range(1, 127)));
    build_expected();
    run_engine("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
